// File: rtl/ram512_dma_engine.sv
// Block-move engine in front of the 512x16 RAM bank: one command either fills
// consecutive words from a write stream or dumps them to a read stream.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_WRITE | streaming wr_data into RAM, one word per wr_valid beat
// S_READ  | streaming RAM words out through the rd_data register
// S_DONE  | one-cycle done pulse, then back to idle
module ram512_dma_engine #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int LW = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_base_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] ram_in_o,
  output logic [AW-1:0] ram_address_o,
  output logic          ram_load_o,
  input  logic [DW-1:0] ram_out_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  assign ram_in_o      = wr_data_i;
  assign ram_address_o = addr_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    ram_load_o  = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          addr_d = cmd_base_i;
          rem_d  = cmd_len_i;
          if (cmd_len_i == '0)
            state_d = S_DONE;
          else if (cmd_write_i)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end

      S_WRITE: begin
        wr_ready_o = 1'b1;
        // Reset gates the strobe so an abandoned beat never reaches the RAM.
        ram_load_o = wr_valid_i & ~reset_i;
        if (wr_valid_i) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1))
            state_d = S_DONE;
        end
      end

      S_READ: begin
        if (!rd_valid_q || rd_ready_i) begin
          if (rem_q != '0) begin
            rd_data_d  = ram_out_i;
            rd_valid_d = 1'b1;
            addr_d     = addr_q + AW'(1);
            rem_d      = rem_q - LW'(1);
          end else begin
            rd_valid_d = 1'b0;
          end
        end
        if (rem_q == '0 && rd_valid_q && rd_ready_i)
          state_d = S_DONE;
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram512_dma_engine.sv
// Bench for ram512_dma_engine: cycle-by-cycle vector table plus directed
// sequences for back-to-back reads, mid-command reset and held cmd_valid.
module tb_ram512_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_base;
  logic [9:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, done;
  logic [15:0] ram_in;
  logic [8:0]  ram_address;
  logic        ram_load;
  logic [15:0] ram_out;

  logic [15:0] mem [512] = '{default: 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  ram512_dma_engine #(.AW(9), .DW(16), .LW(10)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .busy_o(busy), .done_o(done),
    .ram_in_o(ram_in), .ram_address_o(ram_address), .ram_load_o(ram_load),
    .ram_out_i(ram_out)
  );

  typedef struct {
    logic        cv, cw;
    logic [8:0]  base;
    logic [9:0]  len;
    logic        wv;
    logic [15:0] wd;
    logic        rr;
    logic        e_cr, e_wr, e_busy, e_done, e_load;
    logic [8:0]  e_addr;
    logic        e_rv;
    logic [15:0] e_rd;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input int cv, input int cw, input int base, input int len,
                              input int wv, input int wd, input int rr,
                              input int cr, input int wr, input int bz, input int dn,
                              input int ld, input int ad, input int rv, input int rd);
    vec_t v;
    v.cv = 1'(cv); v.cw = 1'(cw); v.base = 9'(base); v.len = 10'(len);
    v.wv = 1'(wv); v.wd = 16'(wd); v.rr = 1'(rr);
    v.e_cr = 1'(cr); v.e_wr = 1'(wr); v.e_busy = 1'(bz); v.e_done = 1'(dn);
    v.e_load = 1'(ld); v.e_addr = 9'(ad); v.e_rv = 1'(rv); v.e_rd = 16'(rd);
    return v;
  endfunction

  task automatic drive(input logic cv, input logic cw, input logic [8:0] base,
                       input logic [9:0] len, input logic wv, input logic [15:0] wd,
                       input logic rr);
    cmd_valid = cv; cmd_write = cw; cmd_base = base; cmd_len = len;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
  endtask

  vec_t tbl [26];

  initial begin
    int busy_n, rv_n, done_n, first_rv, last_rv, got_n, acc_n, acc2_idx;
    logic [15:0] got [8];

    //            cv cw base   len wv wd       rr  cr wr bz dn ld addr   rv rd
    tbl[0]  = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  1, 0, 0, 0, 0, 'h000, 0, 'h0000);
    tbl[1]  = mk(1, 1, 'h1FE, 4, 1, 'hAAAA, 0,  1, 0, 0, 0, 0, 'h000, 0, 'h0000);
    tbl[2]  = mk(0, 0, 'h000, 0, 1, 'h1111, 0,  0, 1, 1, 0, 1, 'h1FE, 0, 'h0000);
    tbl[3]  = mk(0, 0, 'h000, 0, 0, 'h9999, 0,  0, 1, 1, 0, 0, 'h1FF, 0, 'h0000);
    tbl[4]  = mk(0, 0, 'h000, 0, 1, 'h2222, 0,  0, 1, 1, 0, 1, 'h1FF, 0, 'h0000);
    tbl[5]  = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 1, 1, 0, 0, 'h000, 0, 'h0000);
    tbl[6]  = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 1, 1, 0, 0, 'h000, 0, 'h0000);
    tbl[7]  = mk(0, 0, 'h000, 0, 1, 'h3333, 0,  0, 1, 1, 0, 1, 'h000, 0, 'h0000);
    tbl[8]  = mk(0, 0, 'h000, 0, 1, 'h4444, 0,  0, 1, 1, 0, 1, 'h001, 0, 'h0000);
    tbl[9]  = mk(0, 0, 'h000, 0, 1, 'h5555, 0,  0, 0, 1, 1, 0, 'h002, 0, 'h0000);
    tbl[10] = mk(1, 0, 'h1FE, 4, 0, 'h0000, 0,  1, 0, 0, 0, 0, 'h002, 0, 'h0000);
    tbl[11] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 0, 0, 'h1FE, 0, 'h0000);
    tbl[12] = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 0, 1, 0, 0, 'h1FF, 1, 'h1111);
    tbl[13] = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 0, 1, 0, 0, 'h1FF, 1, 'h1111);
    tbl[14] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 0, 0, 'h1FF, 1, 'h1111);
    tbl[15] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 0, 0, 'h000, 1, 'h2222);
    tbl[16] = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 0, 1, 0, 0, 'h001, 1, 'h3333);
    tbl[17] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 0, 0, 'h001, 1, 'h3333);
    tbl[18] = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  0, 0, 1, 0, 0, 'h002, 1, 'h4444);
    tbl[19] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 0, 0, 'h002, 1, 'h4444);
    tbl[20] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 1, 0, 'h002, 0, 'h4444);
    tbl[21] = mk(1, 1, 'h055, 0, 1, 'h7777, 0,  1, 0, 0, 0, 0, 'h002, 0, 'h4444);
    tbl[22] = mk(0, 0, 'h000, 0, 1, 'h7777, 0,  0, 0, 1, 1, 0, 'h055, 0, 'h4444);
    tbl[23] = mk(1, 0, 'h0AA, 0, 0, 'h0000, 1,  1, 0, 0, 0, 0, 'h055, 0, 'h4444);
    tbl[24] = mk(0, 0, 'h000, 0, 0, 'h0000, 1,  0, 0, 1, 1, 0, 'h0AA, 0, 'h4444);
    tbl[25] = mk(0, 0, 'h000, 0, 0, 'h0000, 0,  1, 0, 0, 0, 0, 'h0AA, 0, 'h4444);

    reset = 1'b1;
    drive(0, 0, 9'h0, 10'h0, 0, 16'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Gapped wrapping write, stalled wrapping read, zero-length commands.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i].cv, tbl[i].cw, tbl[i].base, tbl[i].len, tbl[i].wv, tbl[i].wd, tbl[i].rr);
      #1;
      chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_cr));
      chk($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("v%0d ram_load", i), 32'(ram_load), 32'(tbl[i].e_load));
      chk($sformatf("v%0d ram_address", i), 32'(ram_address), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d ram_in", i), 32'(ram_in), 32'(tbl[i].wd));
    end
    chk("mem[1FE]", 32'(mem[9'h1FE]), 32'h1111);
    chk("mem[1FF]", 32'(mem[9'h1FF]), 32'h2222);
    chk("mem[000]", 32'(mem[9'h000]), 32'h3333);
    chk("mem[001]", 32'(mem[9'h001]), 32'h4444);
    chk("mem[002] untouched", 32'(mem[9'h002]), 32'h0000);
    chk("mem[055] untouched", 32'(mem[9'h055]), 32'h0000);

    // Full-rate read, len 3 across the wrap.
    @(negedge clk);
    drive(1, 0, 9'h1FF, 10'd3, 0, 16'h0, 1);
    #1;
    chk("rd3 accept", 32'(cmd_ready), 32'h1);
    busy_n = 0; rv_n = 0; done_n = 0; first_rv = -1; last_rv = -1; got_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (busy) busy_n++;
      if (done) done_n++;
      if (rd_valid) begin
        rv_n++;
        if (first_rv < 0) first_rv = k;
        last_rv = k;
        if (got_n < 8) got[got_n] = rd_data;
        got_n++;
      end
    end
    chk("rd3 busy cycles", 32'(busy_n), 32'd5);
    chk("rd3 rd_valid cycles", 32'(rv_n), 32'd3);
    chk("rd3 rd_valid contiguous", 32'(last_rv - first_rv + 1), 32'd3);
    chk("rd3 done pulses", 32'(done_n), 32'd1);
    chk("rd3 word0", 32'(got[0]), 32'h2222);
    chk("rd3 word1", 32'(got[1]), 32'h3333);
    chk("rd3 word2", 32'(got[2]), 32'h4444);

    // Reset after two of five write beats.
    done_n = 0;
    @(negedge clk);
    drive(1, 1, 9'h100, 10'd5, 0, 16'h0, 0);
    @(negedge clk);
    drive(0, 0, 9'h0, 10'h0, 1, 16'hBEE0, 0);
    #1 if (done) done_n++;
    @(negedge clk);
    wr_data = 16'hBEE1;
    #1 if (done) done_n++;
    @(negedge clk);
    reset = 1'b1;
    wr_data = 16'hBEE2;
    #1;
    chk("rst ram_load in reset cycle", 32'(ram_load), 32'h0);
    if (done) done_n++;
    @(negedge clk);
    reset = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("rst cmd_ready after", 32'(cmd_ready), 32'h1);
    chk("rst busy after", 32'(busy), 32'h0);
    chk("rst addr after", 32'(ram_address), 32'h0);
    chk("rst rd_data after", 32'(rd_data), 32'h0);
    chk("rst wr_ready after", 32'(wr_ready), 32'h0);
    if (done) done_n++;
    chk("rst no done pulse", 32'(done_n), 32'd0);
    chk("rst mem[100]", 32'(mem[9'h100]), 32'hBEE0);
    chk("rst mem[101]", 32'(mem[9'h101]), 32'hBEE1);
    chk("rst mem[102]", 32'(mem[9'h102]), 32'h0000);

    // cmd_valid held through an active read; the second command waits for idle.
    @(negedge clk);
    drive(1, 0, 9'h100, 10'd2, 0, 16'h0, 1);
    #1;
    chk("hold first accept", 32'(cmd_ready), 32'h1);
    acc_n = 1; acc2_idx = -1; done_n = 0; got_n = 0;
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      cmd_base = 9'h1FE;
      cmd_len  = 10'd1;
      cmd_valid = (acc_n < 2);
      #1;
      if (cmd_valid && cmd_ready) begin
        acc_n++;
        acc2_idx = k;
      end
      if (done) done_n++;
      if (rd_valid && rd_ready) begin
        if (got_n < 8) got[got_n] = rd_data;
        got_n++;
      end
    end
    chk("hold second accept cycle", 32'(acc2_idx), 32'd5);
    chk("hold words", 32'(got_n), 32'd3);
    chk("hold word0", 32'(got[0]), 32'hBEE0);
    chk("hold word1", 32'(got[1]), 32'hBEE1);
    chk("hold word2", 32'(got[2]), 32'h1111);
    chk("hold done pulses", 32'(done_n), 32'd2);
    chk("hold final addr", 32'(ram_address), 32'h1FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
